// File: rtl/fpaddsub_normalize_pipe.sv
// fpaddsub_normalize_pipe: two-stage FP add/sub normalize with internal LZC.
// Define NORM_SUBNORM_CLAMP_EN to clamp the shift for gradual underflow.
module fpaddsub_normalize_pipe #(
  parameter int MW = 23,
  parameter int EW = 8
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          InValid,
  output logic          InReady,
  input  logic [MW+2:0] Sum,
  input  logic          G,
  input  logic          PS,
  input  logic [EW-1:0] CExp,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [MW-1:0] NormM,
  output logic [EW:0]   NormE,
  output logic          ZeroSum,
  output logic          NegE,
  output logic          OvfE,
  output logic          R,
  output logic          S
);

  localparam int LW = $clog2(MW + 3);

  typedef struct packed {
    logic [MW+2:0] sum;
    logic          g;
    logic          ps;
    logic [EW-1:0] cExp;
    logic [LW-1:0] lz;
  } s1_t;

  typedef struct packed {
    logic [MW-1:0] m;
    logic [EW:0]   e;
    logic          zero;
    logic          neg;
    logic          ovf;
    logic          r;
    logic          s;
  } s2_t;

  logic v1;
  logic v2;
  logic load2;
  s1_t  s1D;
  s1_t  s1Q;
  s2_t  s2D;
  s2_t  s2Q;

  assign load2   = ~v2 | OutReady;
  assign InReady = ~v1 | ~v2 | OutReady;

  always_comb begin
    s1D.sum  = Sum;
    s1D.g    = G;
    s1D.ps   = PS;
    s1D.cExp = CExp;
    s1D.lz   = LW'(MW + 2);
    for (int i = 0; i <= MW + 1; i++) begin
      if (Sum[i]) s1D.lz = LW'(MW + 1 - i);
    end
  end

  logic [EW:0]   lExt;
  logic [EW:0]   ls;
  logic [EW:0]   eSub;
  logic [MW+1:0] yLo;
`ifdef NORM_SUBNORM_CLAMP_EN
  logic [EW:0]   cLim;
  logic          yTop;
`endif

  always_comb begin
    lExt = (EW + 1)'(s1Q.lz);
`ifdef NORM_SUBNORM_CLAMP_EN
    // never shift the exponent below 1; leftover zeros stay subnormal
    cLim = {1'b0, s1Q.cExp} - (EW + 1)'(1);
    if (s1Q.cExp == '0) ls = '0;
    else if (lExt < cLim) ls = lExt;
    else ls = cLim;
    {yTop, yLo} = {s1Q.sum[MW+1:0], s1Q.g} << ls;
`else
    ls  = lExt;
    yLo = {s1Q.sum[MW:0], s1Q.g} << ls;
`endif
    eSub = {1'b0, s1Q.cExp} - ls;
  end

  always_comb begin
    s2D = '0;
    unique case (1'b1)
      ~|{s1Q.sum, s1Q.g}: begin
        s2D.zero = 1'b1;
      end
      s1Q.sum[MW+2]: begin
        s2D.m   = s1Q.sum[MW+1:2];
        s2D.r   = s1Q.sum[1];
        s2D.s   = s1Q.sum[0] | s1Q.g | s1Q.ps;
        s2D.e   = {1'b0, s1Q.cExp} + (EW + 1)'(1);
        s2D.ovf = s2D.e[EW];
      end
      default: begin
        s2D.m = yLo[MW+1:2];
        s2D.r = yLo[1];
        s2D.s = yLo[0] | s1Q.ps;
`ifdef NORM_SUBNORM_CLAMP_EN
        s2D.e = yTop ? eSub : '0;
`else
        s2D.e   = eSub;
        s2D.neg = eSub[EW];
`endif
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      s1Q <= '0;
      s2Q <= '0;
    end else begin
      if (InReady) v1 <= InValid;
      if (InReady & InValid) s1Q <= s1D;
      if (load2) v2 <= v1;
      if (load2 & v1) s2Q <= s2D;
    end
  end

  assign OutValid = v2;
  assign NormM    = s2Q.m;
  assign NormE    = s2Q.e;
  assign ZeroSum  = s2Q.zero;
  assign NegE     = s2Q.neg;
  assign OvfE     = s2Q.ovf;
  assign R        = s2Q.r;
  assign S        = s2Q.s;

endmodule

// File: tb/tb_fpaddsub_normalize_pipe.sv
// tb_fpaddsub_normalize_pipe: directed vectors against an arithmetic model.
// Honours NORM_SUBNORM_CLAMP_EN the same way the design does.
module tb_fpaddsub_normalize_pipe;
  localparam int MW = 23;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [MW+2:0] Sum = '0;
  logic          G = 1'b0;
  logic          PS = 1'b0;
  logic [EW-1:0] CExp = '0;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [MW-1:0] NormM;
  logic [EW:0]   NormE;
  logic          ZeroSum;
  logic          NegE;
  logic          OvfE;
  logic          R;
  logic          S;

  fpaddsub_normalize_pipe #(.MW(MW), .EW(EW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .InValid(InValid), .InReady(InReady),
    .Sum(Sum), .G(G), .PS(PS), .CExp(CExp),
    .OutValid(OutValid), .OutReady(OutReady),
    .NormM(NormM), .NormE(NormE), .ZeroSum(ZeroSum),
    .NegE(NegE), .OvfE(OvfE), .R(R), .S(S)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [MW-1:0] m;
    logic [EW:0]   e;
    logic          z;
    logic          n;
    logic          o;
    logic          r;
    logic          s;
  } res_t;

  typedef struct packed {
    res_t mdl;
    logic hasLit;
    res_t lit;
  } sb_t;

  res_t act;
  assign act = {NormM, NormE, ZeroSum, NegE, OvfE, R, S};

  sb_t sbQ[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  function automatic res_t mk(input logic [MW-1:0] m, input logic [EW:0] e,
                              input logic z, input logic n, input logic o,
                              input logic r, input logic s);
    res_t x;
    x = {m, e, z, n, o, r, s};
    return x;
  endfunction

  // value-level model: normalise the magnitude, then slice fields
  function automatic res_t model(input logic [MW+2:0] sm, input logic g,
                                 input logic ps, input logic [EW-1:0] ce);
    res_t   o;
    longint frac;
    longint mag;
    longint y;
    int     l;
    int     ls;
    int     e;
    o = '0;
    if (sm == '0 && !g) begin
      o.z = 1'b1;
      return o;
    end
    if (sm[MW+2]) begin
      o.m = MW'(sm >> 2);
      o.r = sm[1];
      o.s = sm[0] | g | ps;
      e   = int'(ce) + 1;
      o.e = (EW + 1)'(e);
      o.o = (e >= (1 << EW));
      return o;
    end
    frac = longint'(sm[MW+1:0]);
    l = 0;
    while (l < MW + 2 && frac < (longint'(1) << (MW + 1 - l))) l++;
    ls = l;
`ifdef NORM_SUBNORM_CLAMP_EN
    if (ce == '0) ls = 0;
    else if (l > int'(ce) - 1) ls = int'(ce) - 1;
`endif
    mag = frac * 2 + longint'(g);
    y   = (mag << ls) & ((longint'(1) << (MW + 3)) - 1);
    o.m = MW'(y >> 2);
    o.r = y[1];
    o.s = y[0] | ps;
    e   = int'(ce) - ls;
`ifdef NORM_SUBNORM_CLAMP_EN
    o.e = y[MW+2] ? (EW + 1)'(e) : '0;
`else
    o.e = (EW + 1)'(e);
    o.n = (e < 0);
`endif
    return o;
  endfunction

  // call at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [MW+2:0] sm, input logic g, input logic ps,
                      input logic [EW-1:0] ce, input logic hl, input res_t lit,
                      output int waits);
    bit  acc;
    sb_t ent;
    acc   = 1'b0;
    waits = 0;
    Sum = sm; G = g; PS = ps; CExp = ce;
    InValid = 1'b1;
    while (!acc && waits < 50) begin
      #1;
      if (InReady) begin
        acc = 1'b1;
        ent.mdl = model(sm, g, ps, ce);
        ent.hasLit = hl;
        ent.lit = lit;
        sbQ.push_back(ent);
      end
      @(negedge CLK);
      waits++;
    end
    InValid = 1'b0;
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic latCheck();
    #1 chk("lat_cycle1", 64'(OutValid), 64'(0));
    @(negedge CLK);
    #1 chk("lat_cycle2", 64'(OutValid), 64'(1));
    @(negedge CLK);
  endtask

  initial begin
    res_t hv;
    bit   held;
    sb_t  e;
    held = 1'b0;
    hv   = '0;
    forever begin
      @(negedge CLK);
      #2;
      if (!RSTn) begin
        held = 1'b0;
      end else begin
        if (held) chk("stable", 64'({OutValid, act}), 64'({1'b1, hv}));
        held = OutValid && !OutReady;
        hv   = act;
        if (OutValid && OutReady) begin
          if (sbQ.size() == 0) begin
            chk("extra_beat", 64'(1), 64'(0));
          end else begin
            e = sbQ.pop_front();
            chk("model", 64'(act), 64'(e.mdl));
            if (e.hasLit) chk("literal", 64'(act), 64'(e.lit));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int tot;
    res_t l3;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_outvalid", 64'(OutValid), 64'(0));
    chk("rst_inready", 64'(InReady), 64'(1));
    chk("rst_data", 64'(act), 64'(0));
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);

    send(26'h2000001, 1'b1, 1'b0, 8'h80, 1'b1,
         mk(23'h0, 9'h081, 0, 0, 0, 0, 1), w);
    latCheck();

    send(26'h2000001, 1'b1, 1'b0, 8'hFF, 1'b1,
         mk(23'h0, 9'h100, 0, 0, 1, 0, 1), w);
    send(26'h0000400, 1'b0, 1'b0, 8'h90, 1'b1,
         mk(23'h0, 9'h082, 0, 0, 0, 0, 0), w);
`ifdef NORM_SUBNORM_CLAMP_EN
    l3 = mk(23'h002000, 9'h000, 0, 0, 0, 0, 0);
`else
    l3 = mk(23'h0, 9'h1F7, 0, 1, 0, 0, 0);
`endif
    send(26'h0000400, 1'b0, 1'b0, 8'h05, 1'b1, l3, w);
    send(26'h0, 1'b0, 1'b1, 8'h7F, 1'b1,
         mk(23'h0, 9'h000, 1, 0, 0, 0, 0), w);
    send(26'h1000005, 1'b1, 1'b0, 8'h10, 1'b1,
         mk(23'h000002, 9'h010, 0, 0, 0, 1, 1), w);
    send(26'h0800003, 1'b0, 1'b1, 8'h20, 1'b1,
         mk(23'h000003, 9'h01F, 0, 0, 0, 0, 1), w);
    send(26'h0, 1'b1, 1'b0, 8'h30, 1'b1,
         mk(23'h0, 9'h017, 0, 0, 0, 0, 0), w);

    tot = 0;
    for (int k = 0; k < 26; k++) begin
      send(26'(64'd1 << k), k[0], k[1], 8'(k * 9 + 3), 1'b0, '0, w);
      tot += w;
    end
    chk("throughput_waits", 64'(tot), 64'(26));

    OutReady = 1'b0;
    fork
      begin
        send(26'h1234567, 1'b1, 1'b1, 8'h40, 1'b0, '0, w);
        send(26'h0012345, 1'b0, 1'b0, 8'h08, 1'b0, '0, w);
        send(26'h3FFFFFF, 1'b1, 1'b0, 8'hFE, 1'b0, '0, w);
      end
      begin
        repeat (2) @(negedge CLK);
        #1 chk("bp_inready_low", 64'(InReady), 64'(0));
        repeat (3) @(negedge CLK);
        OutReady = 1'b1;
      end
    join

    for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge CLK);
    chk("drain_bp", 64'(sbQ.size()), 64'(0));
    @(negedge CLK);

    OutReady = 1'b0;
    send(26'h0000F00, 1'b0, 1'b0, 8'h60, 1'b0, '0, w);
    @(negedge CLK);
    #1 chk("pre_rst_valid", 64'(OutValid), 64'(1));
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_outvalid", 64'(OutValid), 64'(0));
    chk("midrst_data", 64'(act), 64'(0));
    chk("midrst_inready", 64'(InReady), 64'(1));
    sbQ.delete();
    @(negedge CLK);
    #3 RSTn = 1'b1;
    @(negedge CLK);
    OutReady = 1'b1;
    send(26'h1000005, 1'b1, 1'b0, 8'h10, 1'b1,
         mk(23'h000002, 9'h010, 0, 0, 0, 1, 1), w);
    latCheck();

    for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge CLK);
    chk("drain_final", 64'(sbQ.size()), 64'(0));
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
